controle_contador: RTL

Command controller and two-requester arbiter for the shared 8-bit up/down counter (`contador8bitsUpDown`). It accepts LOAD / step-UP / step-DOWN / READ commands from two requesters over valid/ready handshakes and arbitrates between them round-robin. It sequences the counter's `load`, `key` and `entrada` pins so each command runs atomically, then reports completion with the resulting count. It sits between the counter and its two clients and is the only driver of the counter's control pins.

---
 rtl/controle_contador.sv | 138 +++++++++++++
 1 files changed

// File: rtl/controle_contador.sv
// Command sequencer and round-robin arbiter for the shared 8-bit up/down counter.
// Runs LOAD/UP/DOWN/READ atomically and reports completion with the resulting count.
module controle_contador (
    input  logic       clock,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic [1:0] req0_op,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [1:0] req1_op,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    input  logic [7:0] cnt_count,
    output logic       cnt_load,
    output logic       cnt_key,
    output logic [7:0] cnt_entrada,
    output logic       busy,
    output logic       done,
    output logic       done_id,
    output logic [7:0] result
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_STEP,
        S_DONE
    } state_t;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_UP   = 2'b01;
    localparam logic [1:0] OP_DOWN = 2'b10;

    state_t     state_q;
    logic       last_q;
    logic       id_q;
    logic [7:0] data_q;
    logic [7:0] rem_q;
    logic       load_q;
    logic       key_q;
    logic       done_q;

    logic       grant_id;
    logic [1:0] g_op;
    logic [7:0] g_data;
    logic       accept;
    logic       is_step;

    // Contention goes to whoever was not granted last.
    always_comb begin
        grant_id = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_id = ~last_q;
        end else if (req1_valid) begin
            grant_id = 1'b1;
        end
        g_op   = grant_id ? req1_op : req0_op;
        g_data = grant_id ? req1_data : req0_data;
    end

    assign accept  = reset && (state_q == S_IDLE)
                     && (req0_valid || req1_valid);
    assign is_step = ((g_op == OP_UP) || (g_op == OP_DOWN))
                     && (g_data != 8'd0);

    assign req0_ready = accept && !grant_id;
    assign req1_ready = accept && grant_id;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            last_q  <= 1'b1;
            id_q    <= 1'b0;
            data_q  <= 8'd0;
            rem_q   <= 8'd0;
            load_q  <= 1'b1;
            key_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        last_q <= grant_id;
                        id_q   <= grant_id;
                        data_q <= g_data;
                        unique case (1'b1)
                            (g_op == OP_LOAD): begin
                                state_q <= S_LOAD;
                            end
                            is_step: begin
                                state_q <= S_STEP;
                                rem_q   <= g_data;
                                load_q  <= 1'b0;
                                key_q   <= (g_op == OP_UP);
                            end
                            default: begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                            end
                        endcase
                    end
                end
                S_LOAD: begin
                    state_q <= S_DONE;
                    done_q  <= 1'b1;
                end
                S_STEP: begin
                    if (rem_q == 8'd1) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        load_q  <= 1'b1;
                        key_q   <= 1'b0;
                    end else begin
                        rem_q <= rem_q - 8'd1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Frozen counter reloads its own value on the falling edge, except in LOAD.
    assign cnt_entrada = (state_q == S_LOAD) ? data_q : cnt_count;
    assign cnt_load    = load_q;
    assign cnt_key     = key_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign done_id     = done_q && id_q;
    assign result      = done_q ? cnt_count : 8'd0;

endmodule
